// File: rtl/motor_axi_pkg.sv
// Shared constants for the motor peripheral AXI4-Lite register bank.
// Offsets, response codes and the register-index one-hot helper.
package motor_axi_pkg;

    localparam int unsigned NUM_REGS = 4;

    localparam logic [3:0] REG_CTRL   = 4'h0;
    localparam logic [3:0] REG_PERIOD = 4'h4;
    localparam logic [3:0] REG_DUTY   = 4'h8;
    localparam logic [3:0] REG_AUX    = 4'hC;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [1:0] idx);
        logic [NUM_REGS-1:0] one;
        one = {{(NUM_REGS-1){1'b0}}, 1'b1};
        return one << idx;
    endfunction

endpackage

// File: rtl/motor_axi_regfile.sv
// Four byte-strobed 32-bit registers with one write port and one read port.
// Reads are combinational from the current state, so a same-edge write is not visible.
module motor_axi_regfile
    import motor_axi_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    we_i,
    input  logic [1:0]              widx_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic [DATA_WIDTH/8-1:0] wstrb_i,
    input  logic [1:0]              ridx_i,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic [DATA_WIDTH-1:0]   reg0_o,
    output logic [DATA_WIDTH-1:0]   reg1_o,
    output logic [DATA_WIDTH-1:0]   reg2_o,
    output logic [DATA_WIDTH-1:0]   reg3_o
);

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

    always_comb begin
        regs_d = regs_q;
        if (we_i) begin
            for (int b = 0; b < DATA_WIDTH / 8; b++) begin
                if (wstrb_i[b]) begin
                    regs_d[widx_i][8*b +: 8] = wdata_i[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rdata_o = regs_q[ridx_i];
    assign reg0_o  = regs_q[0];
    assign reg1_o  = regs_q[1];
    assign reg2_o  = regs_q[2];
    assign reg3_o  = regs_q[3];

endmodule

// File: rtl/motor_axi_slave.sv
// AXI4-Lite responder for the motor register bank: independent AW/W capture,
// single outstanding write and read, OKAY-only responses.
module motor_axi_slave
    import motor_axi_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                    MOTOR_AXI_ACLK,
    input  logic                    MOTOR_AXI_ARESET,
    input  logic [ADDR_WIDTH-1:0]   MOTOR_AXI_AWADDR,
    input  logic [2:0]              MOTOR_AXI_AWPROT,
    input  logic                    MOTOR_AXI_AWVALID,
    output logic                    MOTOR_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]   MOTOR_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0] MOTOR_AXI_WSTRB,
    input  logic                    MOTOR_AXI_WVALID,
    output logic                    MOTOR_AXI_WREADY,
    output logic [1:0]              MOTOR_AXI_BRESP,
    output logic                    MOTOR_AXI_BVALID,
    input  logic                    MOTOR_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]   MOTOR_AXI_ARADDR,
    input  logic [2:0]              MOTOR_AXI_ARPROT,
    input  logic                    MOTOR_AXI_ARVALID,
    output logic                    MOTOR_AXI_ARREADY,
    output logic [DATA_WIDTH-1:0]   MOTOR_AXI_RDATA,
    output logic [1:0]              MOTOR_AXI_RRESP,
    output logic                    MOTOR_AXI_RVALID,
    input  logic                    MOTOR_AXI_RREADY,
    output logic [DATA_WIDTH-1:0]   reg0_o,
    output logic [DATA_WIDTH-1:0]   reg1_o,
    output logic [DATA_WIDTH-1:0]   reg2_o,
    output logic [DATA_WIDTH-1:0]   reg3_o,
    output logic [NUM_REGS-1:0]     reg_wr_o
);

    logic                    aw_hold_q, aw_hold_d;
    logic [1:0]              aw_idx_q, aw_idx_d;
    logic                    w_hold_q, w_hold_d;
    logic [DATA_WIDTH-1:0]   w_data_q, w_data_d;
    logic [DATA_WIDTH/8-1:0] w_strb_q, w_strb_d;
    logic                    bvalid_q, bvalid_d;
    logic                    rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [NUM_REGS-1:0]     reg_wr_q, reg_wr_d;

    logic                    aw_hs, w_hs, ar_hs, commit;
    logic [1:0]              commit_idx;
    logic [DATA_WIDTH-1:0]   commit_data;
    logic [DATA_WIDTH/8-1:0] commit_strb;
    logic [DATA_WIDTH-1:0]   rf_rdata;

    // Address bits outside [3:2] and the PROT fields carry no meaning here.
    logic unused_ok;
    assign unused_ok = ^{MOTOR_AXI_AWPROT, MOTOR_AXI_ARPROT, MOTOR_AXI_AWADDR, MOTOR_AXI_ARADDR};

    // READY depends only on registered state and reset, never on VALID.
    assign MOTOR_AXI_AWREADY = !aw_hold_q && !bvalid_q && !MOTOR_AXI_ARESET;
    assign MOTOR_AXI_WREADY  = !w_hold_q && !bvalid_q && !MOTOR_AXI_ARESET;
    assign MOTOR_AXI_ARREADY = !rvalid_q && !MOTOR_AXI_ARESET;

    assign aw_hs = MOTOR_AXI_AWVALID && MOTOR_AXI_AWREADY;
    assign w_hs  = MOTOR_AXI_WVALID && MOTOR_AXI_WREADY;
    assign ar_hs = MOTOR_AXI_ARVALID && MOTOR_AXI_ARREADY;

    always_comb begin
        commit_idx  = aw_hs ? MOTOR_AXI_AWADDR[3:2] : aw_idx_q;
        commit_data = w_hs ? MOTOR_AXI_WDATA : w_data_q;
        commit_strb = w_hs ? MOTOR_AXI_WSTRB : w_strb_q;
        commit      = (aw_hold_q || aw_hs) && (w_hold_q || w_hs) && !MOTOR_AXI_ARESET;

        aw_hold_d = aw_hold_q;
        aw_idx_d  = aw_idx_q;
        w_hold_d  = w_hold_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        reg_wr_d  = '0;

        if (aw_hs) begin
            aw_hold_d = 1'b1;
            aw_idx_d  = MOTOR_AXI_AWADDR[3:2];
        end
        if (w_hs) begin
            w_hold_d = 1'b1;
            w_data_d = MOTOR_AXI_WDATA;
            w_strb_d = MOTOR_AXI_WSTRB;
        end
        if (commit) begin
            aw_hold_d = 1'b0;
            w_hold_d  = 1'b0;
            reg_wr_d  = reg_onehot(commit_idx);
        end

        bvalid_d = commit || (bvalid_q && !MOTOR_AXI_BREADY);
        rvalid_d = ar_hs || (rvalid_q && !MOTOR_AXI_RREADY);
        rdata_d  = ar_hs ? rf_rdata : rdata_q;
    end

    always_ff @(posedge MOTOR_AXI_ACLK) begin
        if (MOTOR_AXI_ARESET) begin
            aw_hold_q <= 1'b0;
            aw_idx_q  <= '0;
            w_hold_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            reg_wr_q  <= '0;
        end else begin
            aw_hold_q <= aw_hold_d;
            aw_idx_q  <= aw_idx_d;
            w_hold_q  <= w_hold_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            bvalid_q  <= bvalid_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            reg_wr_q  <= reg_wr_d;
        end
    end

    motor_axi_regfile #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_regfile (
        .clk_i   (MOTOR_AXI_ACLK),
        .rst_i   (MOTOR_AXI_ARESET),
        .we_i    (commit),
        .widx_i  (commit_idx),
        .wdata_i (commit_data),
        .wstrb_i (commit_strb),
        .ridx_i  (MOTOR_AXI_ARADDR[3:2]),
        .rdata_o (rf_rdata),
        .reg0_o  (reg0_o),
        .reg1_o  (reg1_o),
        .reg2_o  (reg2_o),
        .reg3_o  (reg3_o)
    );

    assign MOTOR_AXI_BVALID = bvalid_q;
    assign MOTOR_AXI_BRESP  = RESP_OKAY;
    assign MOTOR_AXI_RVALID = rvalid_q;
    assign MOTOR_AXI_RDATA  = rdata_q;
    assign MOTOR_AXI_RRESP  = RESP_OKAY;
    assign reg_wr_o         = reg_wr_q;

endmodule
